vc_rand_delay_ctrl: RTL and testbench

Val/rdy flow controller that inserts a pseudo-random number of stall cycles in front of each message passing from a producer to a consumer. It owns a 32-bit Tausworthe generator, draws one delay per message, and sequences the handshake through an IDLE/DELAY/PASS state machine. It sits between test sources/sinks or memory models and the design under test to randomize arrival timing reproducibly from a seed.

---
 rtl/vc_rand_delay_ctrl.sv | 128 ++++++++++++
 tb/tb_vc_rand_delay_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_rand_delay_ctrl.sv
// vc_rand_delay_ctrl
// Val/rdy pass-through that holds off each message by a pseudo-random number
// of stall cycles. Delays come from a 32-bit Tausworthe generator, so arrival
// timing is reproducible from p_seed. With en low the block is a wire.
module vc_rand_delay_ctrl #(
  parameter int          p_msg_nbits   = 32,
  parameter int          p_delay_nbits = 4,
  parameter int          p_max_delay   = 7,
  parameter logic [31:0] p_seed        = 32'hdeadbeef
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PASS  = 2'd2
  } state_e;

  // Only whole chunks lying inside bits [30:0] feed the fold; bit 31 never does.
  localparam int NCHUNK = 31 / p_delay_nbits;

  localparam logic [p_delay_nbits-1:0] MAX_D = p_delay_nbits'(p_max_delay);
  localparam logic [p_delay_nbits-1:0] ONE_D = p_delay_nbits'(1);

  state_e                   state_q, state_d;
  logic [p_delay_nbits-1:0] cnt_q, cnt_d;
  logic [31:0]              rng_q, rng_d;

  logic [31:0]              rng_t;
  logic [31:0]              rng_adv;
  logic [p_delay_nbits-1:0] raw_r;
  logic [p_delay_nbits-1:0] draw_d;

  // State, stall counter and generator registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rng_q   <= p_seed;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rng_q   <= rng_d;
    end
  end

  // Generator step and capped delay folded from the current (pre-advance) state.
  always_comb begin
    rng_t   = rng_q ^ (rng_q >> 17);
    rng_adv = rng_t ^ (rng_t << 15);
    raw_r   = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      raw_r = raw_r ^ rng_q[k*p_delay_nbits +: p_delay_nbits];
    end
    draw_d = (raw_r > MAX_D) ? MAX_D : raw_r;
  end

  // Next-state logic: one draw per message, taken when IDLE first sees in_val.
  // NOTE: every output of a combinational block gets a default up front so
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rng_d   = rng_q;
    if (!en) begin
      // Bypass: park in IDLE so re-enabling starts the message afresh.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_val) begin
            rng_d = rng_adv;
            if (draw_d == '0) begin
              state_d = ST_PASS;
            end else begin
              cnt_d   = draw_d - ONE_D;
              state_d = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          // Counts to completion even if in_val drops; the message then waits in PASS.
          if (cnt_q == '0) begin
            state_d = ST_PASS;
          end else begin
            cnt_d = cnt_q - ONE_D;
          end
        end
        ST_PASS: begin
          if (in_val && out_rdy) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs: transparent in bypass or PASS, blocked otherwise.
  always_comb begin
    out_val = 1'b0;
    in_rdy  = 1'b0;
    if (!en || (state_q == ST_PASS)) begin
      out_val = in_val;
      in_rdy  = out_rdy;
    end
    busy = (state_q == ST_DELAY) || ((state_q == ST_PASS) && in_val);
  end

  // The message is never stored; the consumer sees the producer's bus directly.
  assign out_msg = in_msg;

endmodule

// File: tb/tb_vc_rand_delay_ctrl.sv
// tb_vc_rand_delay_ctrl
// Self-checking bench: reset-state table, bypass, model-driven random delays,
// back-pressure, mid-delay reset and enable toggling.
module tb_vc_rand_delay_ctrl;

  localparam logic [31:0] SEED = 32'hdeadbeef;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        in_val;
  logic        out_rdy;
  logic [31:0] in_msg;

  logic        in_rdy, out_val, busy;
  logic [31:0] out_msg;
  logic        in_rdy0, out_val0, busy0;
  logic [31:0] out_msg0;

  logic        sel0;
  logic        cur_val;

  int n_cmp;
  int n_err;

  logic [31:0] m_s;

  typedef struct {
    logic en;
    logic in_val;
    logic out_rdy;
    logic exp_out_val;
    logic exp_in_rdy;
    logic exp_busy;
  } vec_t;

  vec_t vecs[8];
  int   hist[8];

  vc_rand_delay_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .busy    (busy)
  );

  vc_rand_delay_ctrl #(
    .p_max_delay (0)
  ) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .in_val  (in_val),
    .in_rdy  (in_rdy0),
    .in_msg  (in_msg),
    .out_val (out_val0),
    .out_rdy (out_rdy),
    .out_msg (out_msg0),
    .busy    (busy0)
  );

  assign cur_val = sel0 ? out_val0 : out_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference generator step, written straight from the Tausworthe rule.
  function automatic logic [31:0] m_next(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s >> 17);
    return t ^ (t << 15);
  endfunction

  // XOR of all 4-bit chunks lying within bits 30..0, capped at max_d.
  function automatic int m_delay(input logic [31:0] s, input int max_d);
    int r;
    r = 0;
    for (int k = 0; (k + 1) * 4 - 1 <= 30; k++) begin
      r = r ^ int'((s >> (4 * k)) & 32'hf);
    end
    return (r > max_d) ? max_d : r;
  endfunction

  task automatic m_draw(output int d);
    d   = m_delay(m_s, 7);
    m_s = m_next(m_s);
  endtask

  // Counts rising edges from the current cycle until the observed out_val is high.
  task automatic wait_val(output int lat);
    lat = 0;
    @(negedge clk);
    while (cur_val !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    in_msg  = '0;
    @(posedge clk);
    #4;
    reset_n = 1'b1;
    m_s     = SEED;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, d, d1, j;
    logic [31:0] msg;

    n_cmp   = 0;
    n_err   = 0;
    sel0    = 1'b0;
    reset_n = 1'b0;
    en      = 1'b1;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in_msg  = '0;
    m_s     = SEED;
    for (int i = 0; i < 8; i++) hist[i] = 0;

    // Reset-state table: outputs are pure bypass when en is low, blocked otherwise.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    #3;
    for (int i = 0; i < 8; i++) begin
      en      = vecs[i].en;
      in_val  = vecs[i].in_val;
      out_rdy = vecs[i].out_rdy;
      #2;
      check("rst_out_val", out_val, vecs[i].exp_out_val);
      check("rst_in_rdy",  in_rdy,  vecs[i].exp_in_rdy);
      check("rst_busy",    busy,    vecs[i].exp_busy);
    end

    // Zero-delay instance: back-to-back messages, one fire every two cycles.
    do_reset();
    sel0   = 1'b1;
    in_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_msg = i;
      wait_val(lat);
      check("b2b_lat",    lat,      1);
      check("b2b_msg",    out_msg0, i);
      check("b2b_in_rdy", in_rdy0,  1);
      check("b2b_busy",   busy0,    1);
      @(posedge clk);
      #1;
    end
    sel0 = 1'b0;

    // Bypass with random handshakes; generator must stay at the seed.
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_val  = 1'($urandom_range(0, 1));
      out_rdy = 1'($urandom_range(0, 1));
      in_msg  = $urandom;
      @(negedge clk);
      check("byp_out_val", out_val, in_val);
      check("byp_in_rdy",  in_rdy,  out_rdy);
      check("byp_msg",     out_msg, in_msg);
      @(posedge clk);
      #1;
    end
    en      = 1'b1;
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = 32'h0000_0b1a;
    m_draw(d);
    wait_val(lat);
    check("byp_seed_lat", lat, 1 + d);
    @(posedge clk);
    #1;

    // Random messages with random idle gaps against the generator model.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap    = $urandom_range(0, 2);
      in_val = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_busy",    busy,    0);
        check("gap_out_val", out_val, 0);
        @(posedge clk);
        #1;
      end
      msg    = $urandom;
      in_msg = msg;
      in_val = 1'b1;
      m_draw(d);
      wait_val(lat);
      check("rand_lat",  lat,     1 + d);
      check("rand_msg",  out_msg, msg);
      check("rand_busy", busy,    1);
      if (lat >= 1 && lat <= 8) hist[lat-1]++;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 8; k++) begin
      check("delay_seen", hist[k] != 0, 1);
    end

    // Back-pressure: hold out_rdy low for five cycles once out_val rises.
    do_reset();
    out_rdy = 1'b0;
    in_msg  = 32'hcafe_0001;
    in_val  = 1'b1;
    m_draw(d);
    wait_val(lat);
    check("bp_lat", lat, 1 + d);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_val", out_val, 1);
      check("bp_hold_rdy", in_rdy,  0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    #1;
    check("bp_fire_rdy", in_rdy,  1);
    check("bp_fire_val", out_val, 1);
    @(posedge clk);
    #1;
    in_msg = 32'hcafe_0002;
    m_draw(d);
    wait_val(lat);
    check("bp_draw2_lat", lat,     1 + d);
    check("bp_draw2_msg", out_msg, 32'hcafe_0002);
    @(posedge clk);
    #1;

    // Reset pulse while the counter holds 3; the message is redrawn from the seed.
    do_reset();
    in_msg = 32'h0000_0abc;
    in_val = 1'b1;
    m_draw(d1);
    j = (d1 > 3) ? d1 - 3 : 1;
    repeat (j) @(posedge clk);
    #2;
    check("mid_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_val",  out_val, 0);
    check("mid_rst_rdy",  in_rdy,  0);
    check("mid_rst_busy", busy,    0);
    #1;
    reset_n = 1'b1;
    m_s     = SEED;
    m_draw(d);
    wait_val(lat);
    check("mid_rst_lat", lat, 1 + d);
    @(posedge clk);
    #1;

    // Enable dropped mid-DELAY: bypass delivers, then the next message redraws.
    do_reset();
    in_msg = 32'h0000_aaaa;
    in_val = 1'b1;
    m_draw(d);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("en_delay_busy", busy, 1);
    en = 1'b0;
    #1;
    check("en_byp_val", out_val, 1);
    check("en_byp_rdy", in_rdy,  1);
    check("en_byp_msg", out_msg, 32'h0000_aaaa);
    @(posedge clk);
    #1;
    en     = 1'b1;
    in_msg = 32'h0000_bbbb;
    m_draw(d);
    wait_val(lat);
    check("en_re_lat", lat,     1 + d);
    check("en_re_msg", out_msg, 32'h0000_bbbb);
    @(posedge clk);
    #1;
    in_val = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
